// File: rtl/dmux_sched.sv
// Sequenced 1-to-2 demultiplexer: one valid/ready input stream steered per word
// to two single-entry output channels, with per-channel delivered-word counters.
module dmux_sched #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    output logic [W-1:0]  out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [W-1:0]  out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic          ptr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic          r_full0;
    logic          r_full1;
    logic [W-1:0]  r_data0;
    logic [W-1:0]  r_data1;
    logic          r_ptr;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic          w_tgt;
    logic          w_acc;
    logic          w_load0;
    logic          w_load1;
    logic          w_drain0;
    logic          w_drain1;

    // Target channel for the word currently offered.
    always_comb begin
        w_tgt = r_ptr;
        case (mode)
            2'b00:   w_tgt = r_ptr;
            2'b01:   w_tgt = 1'b0;
            2'b10:   w_tgt = 1'b1;
            2'b11:   w_tgt = in_data[0];
            default: w_tgt = r_ptr;
        endcase
    end

    // Handshake decode; a channel drained this cycle may be reloaded at the same edge.
    always_comb begin
        in_ready = 1'b0;
        if (w_tgt) begin
            in_ready = rst_n & (~r_full1 | out1_ready);
        end else begin
            in_ready = rst_n & (~r_full0 | out0_ready);
        end
        w_acc    = in_valid & in_ready;
        w_load0  = w_acc & ~w_tgt;
        w_load1  = w_acc &  w_tgt;
        w_drain0 = r_full0 & out0_ready;
        w_drain1 = r_full1 & out1_ready;
    end

    // Channel 0 holding register and delivered counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full0 <= 1'b0;
            r_data0 <= {W{1'b0}};
            r_cnt0  <= {CW{1'b0}};
        end else begin
            if (w_load0) begin
                r_full0 <= 1'b1;
                r_data0 <= in_data;
            end else if (w_drain0) begin
                r_full0 <= 1'b0;
            end
            if (w_drain0) begin
                r_cnt0 <= r_cnt0 + CW'(1);
            end
        end
    end

    // Channel 1 holding register and delivered counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full1 <= 1'b0;
            r_data1 <= {W{1'b0}};
            r_cnt1  <= {CW{1'b0}};
        end else begin
            if (w_load1) begin
                r_full1 <= 1'b1;
                r_data1 <= in_data;
            end else if (w_drain1) begin
                r_full1 <= 1'b0;
            end
            if (w_drain1) begin
                r_cnt1 <= r_cnt1 + CW'(1);
            end
        end
    end

    // Round-robin pointer advances only on accepts made in alternate mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_acc && (mode == 2'b00)) begin
            r_ptr <= ~r_ptr;
        end
    end

    // Empty channels drive zero data.
    always_comb begin
        out0_valid = r_full0;
        out1_valid = r_full1;
        out0_data  = r_full0 ? r_data0 : {W{1'b0}};
        out1_data  = r_full1 ? r_data1 : {W{1'b0}};
        ptr        = r_ptr;
        cnt0       = r_cnt0;
        cnt1       = r_cnt1;
    end

endmodule

// File: tb/tb_dmux_sched.sv
// Scoreboard bench for dmux_sched: directed words with hand-assigned channels,
// a negedge monitor checks every delivered word against per-channel queues.
module tb_dmux_sched;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [W-1:0]  out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic          ptr;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    dmux_sched #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .ptr(ptr), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake seen at negedge must match the head of its channel queue.
    always @(negedge clk) begin
        if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
            if (q0.size() == 0) begin
                chk("ch0_unexpected", {24'h0, out0_data}, 32'hFFFF_FFFF);
            end else begin
                chk("ch0_data", {24'h0, out0_data}, {24'h0, q0.pop_front()});
            end
        end
        if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
            if (q1.size() == 0) begin
                chk("ch1_unexpected", {24'h0, out1_data}, 32'hFFFF_FFFF);
            end else begin
                chk("ch1_data", {24'h0, out1_data}, {24'h0, q1.pop_front()});
            end
        end
    end

    // Offer one word; returns 1 time unit after the accepting edge.
    task automatic send(input logic [W-1:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; mode = 2'b00;
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_valids", {30'h0, out1_valid, out0_valid}, 32'd0);
        chk("rst_data", {16'h0, out1_data, out0_data}, 32'd0);
        chk("rst_ptr", {31'h0, ptr}, 32'd0);
        chk("rst_cnts", {28'h0, cnt1, cnt0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;

        // Alternate mode, both consumers ready.
        stalls = 0;
        q0.push_back(8'h10); q1.push_back(8'h11);
        q0.push_back(8'h12); q1.push_back(8'h13);
        send(8'h10);
        chk("alt_lat_valid", {31'h0, out0_valid}, 32'd1);
        chk("alt_lat_data", {24'h0, out0_data}, 32'h10);
        send(8'h11);
        send(8'h12);
        send(8'h13);
        idle(2);
        chk("alt_stalls", stalls, 32'd0);
        chk("alt_ptr", {31'h0, ptr}, 32'd0);
        chk("alt_cnt0", {30'h0, cnt0}, 32'd2);
        chk("alt_cnt1", {30'h0, cnt1}, 32'd2);

        // Backpressure on channel 0 with same-edge drain and reload.
        mode = 2'b01; out0_ready = 1'b0;
        q0.push_back(8'h55); q0.push_back(8'h66);
        send(8'h55);
        in_data = 8'h66; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'h0, out0_valid}, 32'd1);
        chk("bp_hold_data", {24'h0, out0_data}, 32'h55);
        @(posedge clk); #1;
        out0_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_drain", {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out0_ready = 1'b0;
        chk("bp_reload_valid", {31'h0, out0_valid}, 32'd1);
        chk("bp_reload_data", {24'h0, out0_data}, 32'h66);
        chk("bp_cnt0", {30'h0, cnt0}, 32'd3);
        out0_ready = 1'b1;
        idle(1);
        chk("bp_cnt0_wrap", {30'h0, cnt0}, 32'd0);
        chk("bp_drained", {31'h0, out0_valid}, 32'd0);

        // Tag routing on in_data[0].
        mode = 2'b11;
        q1.push_back(8'h01); q0.push_back(8'h02); q1.push_back(8'h03);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        idle(2);
        chk("tag_ptr", {31'h0, ptr}, 32'd0);
        chk("tag_cnt0", {30'h0, cnt0}, 32'd1);
        chk("tag_cnt1", {30'h0, cnt1}, 32'd0);

        // Alternate mode stalling on a blocked channel 1, no skip-ahead.
        mode = 2'b00; out1_ready = 1'b0;
        q0.push_back(8'hA0); q1.push_back(8'hA1); q0.push_back(8'hA2);
        send(8'hA0);
        send(8'hA1);
        send(8'hA2);
        in_data = 8'hA3; in_valid = 1'b1;
        @(negedge clk);
        chk("stall_ptr", {31'h0, ptr}, 32'd1);
        chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        chk("stall_in_ready2", {31'h0, in_ready}, 32'd0);
        chk("stall_hold1", {24'h0, out1_data}, 32'hA1);
        q1.push_back(8'hA3);
        @(posedge clk); #1;
        out1_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall_ptr_after", {31'h0, ptr}, 32'd0);
        idle(2);
        chk("stall_cnt0", {30'h0, cnt0}, 32'd3);
        chk("stall_cnt1", {30'h0, cnt1}, 32'd2);

        // Counter wrap on channel 1, then reset with channel 0 holding a word.
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            q1.push_back(8'hB0 + 8'(i));
            send(8'hB0 + 8'(i));
        end
        idle(2);
        chk("wrap_cnt1", {30'h0, cnt1}, 32'd3);
        mode = 2'b00;
        q0.push_back(8'hD0);
        send(8'hD0);
        idle(1);
        out0_ready = 1'b0; mode = 2'b01;
        send(8'hC0);
        chk("mid_full0", {31'h0, out0_valid}, 32'd1);
        chk("mid_ptr", {31'h0, ptr}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_in_ready_rst", {31'h0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_valid0", {31'h0, out0_valid}, 32'd0);
        chk("mid_data0", {24'h0, out0_data}, 32'd0);
        chk("mid_cnts", {28'h0, cnt1, cnt0}, 32'd0);
        chk("mid_ptr_rst", {31'h0, ptr}, 32'd0);
        out0_ready = 1'b1;
        idle(3);
        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
